// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// The winner's opcode/operands are registered onto the ALU inputs, held for
// SETTLE_CYCLES, and the ALU result is captured and returned with a DONE pulse.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic [OPRN_WIDTH-1:0] OPRN0,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  output logic                  GNT0,
  output logic                  DONE0,
  input  logic                  REQ1,
  input  logic [OPRN_WIDTH-1:0] OPRN1,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  output logic                  GNT1,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO_RES,
  output logic                  BUSY,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_gnt;   // requester granted most recently
  logic       owner;      // requester that owns the current operation
  logic       accept;     // an operation is accepted at this edge
  logic       win1;       // requester 1 wins this arbitration
  logic       capture;    // ALU result is captured at this edge

  // Next-state and arbitration decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    win1      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        // With both requesting, the one not granted last time wins.
        win1   = REQ1 && (!REQ0 || !last_gnt);
        accept = REQ0 || REQ1;
        if (accept) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        capture = (cnt == 4'd1);
        if (capture) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Control registers: grant/done pulses, busy flag, settle counter, fairness
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      BUSY     <= 1'b0;
      cnt      <= 4'd0;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
    end else begin
      GNT0  <= accept && !win1;
      GNT1  <= accept && win1;
      DONE0 <= capture && !owner;
      DONE1 <= capture && owner;
      BUSY  <= (state_nxt != S_IDLE);
      if (accept) begin
        last_gnt <= win1;
        owner    <= win1;
        cnt      <= SETTLE_LD;
      end else if (state == S_EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Data registers: ALU input operands and captured result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALU_OPRN <= '0;
      ALU_OP1  <= '0;
      ALU_OP2  <= '0;
      RESULT   <= '0;
      ZERO_RES <= 1'b0;
    end else begin
      if (accept) begin
        ALU_OPRN <= win1 ? OPRN1 : OPRN0;
        ALU_OP1  <= win1 ? OP1_1 : OP1_0;
        ALU_OP2  <= win1 ? OP2_1 : OP2_0;
      end
      if (capture) begin
        RESULT   <= ALU_OUT;
        ZERO_RES <= ALU_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [5:0]  oprn0, oprn1;
  logic [31:0] op1_0, op2_0, op1_1, op2_1;
  logic        gnt0, gnt1, done0, done1, busy, zero_res;
  logic [31:0] result;
  logic [5:0]  alu_oprn;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic        alu_zero;

  // second instance with a longer settle time
  logic        s_req0;
  logic [5:0]  s_oprn0;
  logic [31:0] s_op1_0, s_op2_0;
  logic        s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_zero_res;
  logic [31:0] s_result;
  logic [5:0]  s_alu_oprn;
  logic [31:0] s_alu_op1, s_alu_op2, s_alu_out;
  logic        s_alu_zero;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Behavioural ALU used both as the attached ALU and as the reference.
  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      6'h01: return a + b;
      6'h02: return a - b;
      6'h03: return a * b;
      6'h04: return a >> b;
      6'h05: return a << b;
      6'h06: return a & b;
      6'h07: return a | b;
      6'h08: return ~(a | b);
      6'h09: return (a < b) ? 32'd1 : 32'd0;
      default: return 'x;
    endcase
  endfunction

  assign alu_out    = alu_f(alu_oprn, alu_op1, alu_op2);
  assign alu_zero   = (alu_out == 32'd0);
  assign s_alu_out  = alu_f(s_alu_oprn, s_alu_op1, s_alu_op2);
  assign s_alu_zero = (s_alu_out == 32'd0);

  alu_share_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .SETTLE_CYCLES(1)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .OPRN0(oprn0), .OP1_0(op1_0), .OP2_0(op2_0), .GNT0(gnt0), .DONE0(done0),
    .REQ1(req1), .OPRN1(oprn1), .OP1_1(op1_1), .OP2_1(op2_1), .GNT1(gnt1), .DONE1(done1),
    .RESULT(result), .ZERO_RES(zero_res), .BUSY(busy),
    .ALU_OPRN(alu_oprn), .ALU_OP1(alu_op1), .ALU_OP2(alu_op2),
    .ALU_OUT(alu_out), .ALU_ZERO(alu_zero)
  );

  alu_share_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .SETTLE_CYCLES(3)) dut3 (
    .CLK(clk), .RST(rst),
    .REQ0(s_req0), .OPRN0(s_oprn0), .OP1_0(s_op1_0), .OP2_0(s_op2_0),
    .GNT0(s_gnt0), .DONE0(s_done0),
    .REQ1(1'b0), .OPRN1(6'd0), .OP1_1(32'd0), .OP2_1(32'd0),
    .GNT1(s_gnt1), .DONE1(s_done1),
    .RESULT(s_result), .ZERO_RES(s_zero_res), .BUSY(s_busy),
    .ALU_OPRN(s_alu_oprn), .ALU_OP1(s_alu_op1), .ALU_OP2(s_alu_op2),
    .ALU_OUT(s_alu_out), .ALU_ZERO(s_alu_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // control outputs packed as {gnt0,gnt1,done0,done1,busy}
  function automatic logic [4:0] ctl();
    return {gnt0, gnt1, done0, done1, busy};
  endfunction

  initial begin
    logic        m_last;
    logic        r0, r1, win;
    logic [5:0]  eop;
    logic [31:0] ea, eb, eres;

    rst = 1'b1;
    req0 = 0; req1 = 0; oprn0 = 0; oprn1 = 0;
    op1_0 = 0; op2_0 = 0; op1_1 = 0; op2_1 = 0;
    s_req0 = 0; s_oprn0 = 0; s_op1_0 = 0; s_op2_0 = 0;
    tick(); tick();

    // reset state
    chk("rst_ctl", 64'(ctl()), 64'd0);
    chk("rst_res", {31'd0, zero_res, result}, 64'd0);
    chk("rst_alu", 64'(|{alu_oprn, alu_op1, alu_op2}), 64'd0);
    rst = 1'b0;
    tick();

    // single op: 15 + 3
    req0 = 1; oprn0 = 6'h01; op1_0 = 32'd15; op2_0 = 32'd3;
    tick();
    chk("single_gnt", 64'(ctl()), 64'b10001);
    chk("single_alu_in", {26'd0, alu_oprn, alu_op1}, {26'd0, 6'h01, 32'd15});
    tick();
    chk("single_done", 64'(ctl()), 64'b00101);
    chk("single_res", {31'd0, zero_res, result}, {31'd0, 1'b0, 32'd18});
    req0 = 0;
    tick();
    chk("single_idle", 64'(ctl()), 64'd0);
    chk("single_hold", 64'(result), 64'd18);

    // zero flag: 0 - 0, then 15 - 5 with REQ1 kept high across DONE
    req1 = 1; oprn1 = 6'h02; op1_1 = 32'd0; op2_1 = 32'd0;
    tick();
    chk("zero_gnt", 64'(ctl()), 64'b01001);
    tick();
    chk("zero_done", 64'(ctl()), 64'b00011);
    chk("zero_res", {31'd0, zero_res, result}, {31'd0, 1'b1, 32'd0});
    op1_1 = 32'd15; op2_1 = 32'd5;
    tick();
    chk("zero_idle", 64'(ctl()), 64'd0);
    tick();
    chk("sub_gnt", 64'(ctl()), 64'b01001);
    tick();
    chk("sub_done", 64'(ctl()), 64'b00011);
    chk("sub_res", {31'd0, zero_res, result}, {31'd0, 1'b0, 32'd10});
    req1 = 0;
    tick();

    // contention right after reset: requester 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1; oprn0 = 6'h03; op1_0 = 32'd5; op2_0 = 32'd10;
    req1 = 1; oprn1 = 6'h09; op1_1 = 32'd6; op2_1 = 32'd7;
    tick();
    chk("cont_gnt0", 64'(ctl()), 64'b10001);
    tick();
    chk("cont_done0", 64'(ctl()), 64'b00101);
    chk("cont_res0", 64'(result), 64'd50);
    tick();
    chk("cont_idle", 64'(ctl()), 64'd0);
    tick();
    chk("cont_gnt1", 64'(ctl()), 64'b01001);
    tick();
    chk("cont_done1", 64'(ctl()), 64'b00011);
    chk("cont_res1", 64'(result), 64'd1);
    req0 = 0; req1 = 0;
    tick();

    // fairness: both held for six operations, accepts every 3 cycles
    req0 = 1; oprn0 = 6'h06; op1_0 = 32'hF; op2_0 = 32'h1;
    req1 = 1; oprn1 = 6'h07; op1_1 = 32'h1; op2_1 = 32'h5;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fair_gnt%0d", i), 64'(ctl()), (i % 2 == 0) ? 64'b10001 : 64'b01001);
      tick();
      chk($sformatf("fair_done%0d", i), 64'(ctl()), (i % 2 == 0) ? 64'b00101 : 64'b00011);
      chk($sformatf("fair_res%0d", i), 64'(result), (i % 2 == 0) ? 64'd1 : 64'd5);
      if (i == 5) begin
        req0 = 0; req1 = 0;
      end
      tick();
    end

    // reset mid-operation
    req0 = 1; oprn0 = 6'h05; op1_0 = 32'd8; op2_0 = 32'd3;
    tick();
    chk("abort_gnt", 64'(ctl()), 64'b10001);
    rst = 1'b1;
    #1;
    chk("abort_ctl", 64'(ctl()), 64'd0);
    chk("abort_data", 64'(|{zero_res, result, alu_oprn, alu_op1, alu_op2}), 64'd0);
    tick();
    rst = 1'b0; req0 = 0;
    tick();
    chk("abort_nodone", 64'(ctl()), 64'd0);
    req1 = 1; oprn1 = 6'h04; op1_1 = 32'd8; op2_1 = 32'd3;
    tick();
    chk("abort_gnt1", 64'(ctl()), 64'b01001);
    tick();
    chk("abort_done1", 64'(ctl()), 64'b00011);
    chk("abort_res1", 64'(result), 64'd1);
    req1 = 0;
    tick();

    // settle time of 3: NOR(1,4)
    s_req0 = 1; s_oprn0 = 6'h08; s_op1_0 = 32'd1; s_op2_0 = 32'd4;
    tick();
    chk("settle_gnt", {62'd0, s_gnt0, s_gnt1}, 64'b10);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      chk($sformatf("settle_busy%0d", k), 64'(s_busy), 64'd1);
      chk($sformatf("settle_done%0d", k), {62'd0, s_done0, s_done1}, (k == 4) ? 64'b10 : 64'b00);
    end
    chk("settle_res", {31'd0, s_zero_res, s_result}, {31'd0, 1'b0, 32'hFFFF_FFFA});
    s_req0 = 0;
    tick();
    chk("settle_idle", 64'(s_busy), 64'd0);

    // randomized transactions against the transaction-level model
    m_last = 1'b1;
    for (int n = 0; n < 24; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      oprn0 = 6'($urandom_range(1, 9)); op1_0 = $urandom; op2_0 = $urandom_range(0, 31);
      oprn1 = 6'($urandom_range(1, 9)); op1_1 = $urandom; op2_1 = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin
        oprn0 = 6'h02; op2_0 = op1_0;
      end
      req0 = r0; req1 = r1;
      win = (r0 && r1) ? !m_last : r1;
      eop = win ? oprn1 : oprn0;
      ea  = win ? op1_1 : op1_0;
      eb  = win ? op2_1 : op2_0;
      eres = alu_f(eop, ea, eb);
      m_last = win;
      tick();
      chk($sformatf("rnd_gnt%0d", n), 64'(ctl()), win ? 64'b01001 : 64'b10001);
      op1_0 = $urandom; op1_1 = $urandom;
      tick();
      chk($sformatf("rnd_done%0d", n), 64'(ctl()), win ? 64'b00011 : 64'b00101);
      chk($sformatf("rnd_res%0d", n), {31'd0, zero_res, result},
          {31'd0, (eres == 32'd0), eres});
      req0 = 0; req1 = 0;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (OP1/OP2/OPRN in, OUT/ZERO out) between two requesters using a round-robin policy.
- Accepts one operation at a time and registers its operands and opcode onto the ALU inputs.
- Waits a programmable settle time, then captures OUT/ZERO into a result register and returns them with a one-cycle DONE pulse to the winning requester.
- Sits between the control unit / auxiliary datapath masters and the single ALU instance.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- OPRN_WIDTH, 6, opcode width (matches `ALU_OPRN_WIDTH).
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- REQ0  input  1  requester 0 request.
- OPRN0  input  OPRN_WIDTH  requester 0 opcode.
- OP1_0  input  DATA_WIDTH  requester 0 operand 1.
- OP2_0  input  DATA_WIDTH  requester 0 operand 2.
- GNT0  output  1  one-cycle pulse: requester 0 accepted, operands latched.
- DONE0  output  1  one-cycle pulse: requester 0 result valid.
- REQ1, OPRN1, OP1_1, OP2_1, GNT1, DONE1: same as above, for requester 1.
- RESULT  output  DATA_WIDTH  captured ALU OUT; holds until next capture.
- ZERO_RES  output  1  captured ALU ZERO; holds with RESULT.
- BUSY  output  1  high in EXEC and DONE states.
- ALU_OPRN  output  OPRN_WIDTH  to ALU OPRN.
- ALU_OP1  output  DATA_WIDTH  to ALU OP1.
- ALU_OP2  output  DATA_WIDTH  to ALU OP2.
- ALU_OUT  input  DATA_WIDTH  from ALU OUT.
- ALU_ZERO  input  1  from ALU ZERO.

Behaviour:
- Reset: one clock; RST is asynchronous and active-high. While RST is high, all outputs are 0, state is IDLE, counter is 0, and LAST_GNT is 1 (requester 0 wins first).
- A reset mid-operation aborts the operation: no DONE is issued and the request is lost.
- State machine: IDLE, EXEC, DONE. All outputs are registered.
- IDLE:
  - REQ0/REQ1 are sampled only in IDLE.
  - One requesting: it wins.
  - Both requesting: the one not equal to LAST_GNT wins.
  - On the edge: latch the winner's OPRN/OP1/OP2 into ALU_*, pulse GNTx for the next cycle, update LAST_GNT, load counter = SETTLE_CYCLES, go to EXEC.
  - No request: stay in IDLE; ALU_* keep their last values.
- EXEC:
  - Counter decrements each cycle.
  - In the cycle the counter is 1: at the edge, capture RESULT <= ALU_OUT and ZERO_RES <= ALU_ZERO, assert DONEx for the next cycle, go to DONE.
  - REQ changes and operand changes during EXEC are ignored because operands are already latched.
- DONE:
  - Lasts one cycle with DONEx high, then goes to IDLE.
  - The requester drops REQ at the edge ending DONE. A REQ still high in the following IDLE cycle is a new request.
- Latency: REQ high in IDLE cycle t → GNT high in cycle t+1 → DONE high in cycle t+1+SETTLE_CYCLES.
  - Back-to-back accepts occur every SETTLE_CYCLES+2 cycles.
- GNT0/GNT1 are never high together; the same holds for DONE0/DONE1. GNTx and DONEx are never high in the same cycle.
- Fairness: with both REQs held continuously, grants alternate 0,1,0,1...
- RESULT/ZERO_RES pass ALU values unchanged, including X for an undefined opcode. No width conversion.

Test Plan:
- Single op: reset, REQ0 with OPRN0=0x01, OP1_0=15, OP2_0=3 → GNT0 one cycle later, DONE0 two cycles after REQ, RESULT=18, ZERO_RES=0, GNT1/DONE1 stay 0.
- Zero flag: REQ1 with OPRN1=0x02, OP1_1=0, OP2_1=0 → DONE1 pulse, RESULT=0, ZERO_RES=1; then REQ1 with 0x02, 15, 5 → RESULT=10, ZERO_RES=0.
- Contention: after reset, both REQ in the same cycle (REQ0: 0x03, 5*10; REQ1: 0x09, 6<7) → GNT0 first, DONE0 with RESULT=50, next IDLE grants requester 1, DONE1 with RESULT=1.
- Fairness: both REQs held for 6 operations (0x06 0xF&0x1, 0x07 0x1|0x5) → grant order 0,1,0,1,0,1, spacing 3 cycles, DONE values 1 and 5 alternating.
- Reset mid-op: REQ0 with 0x05, 8<<3, assert RST during EXEC → all outputs 0 immediately, no DONE0; after release, REQ1 0x04 8>>3 is granted first via LAST_GNT reset → RESULT=1.
- Settle: SETTLE_CYCLES=3, REQ0 0x08 NOR(1,4) → DONE0 at REQ+4 cycles, RESULT=0xFFFFFFFA, BUSY high for 4 cycles.
